cvita_hdr_framer: RTL and testbench
===================================

// Module: cvita_hdr_framer
// PURPOSE
//  Serialises a 128-bit CVITA header (from cvita_hdr_encoder) plus a 64-bit AXI-Stream payload
//  into one 64-bit CHDR packet stream.
//  Packet order: header word, optional VITA time word, then the payload beats.
//  Sits directly downstream of cvita_hdr_encoder, at the block-output packetizer.
//  Checks the header length field against the actual payload beat count.
// PARAMETERS
//  LEN_CHECK  1  1: enable o_len_err; 0: o_len_err tied 0, no beat counter logic
// PORTS
//  clk             in   1    single clock; all logic on rising edge
//  reset           in   1    asynchronous, active-high
//  i_hdr           in   128  {hdr_word[127:64], vita_time[63:0]}; bit125=has_time, [111:96]=length (bytes)
//  i_hdr_tvalid    in   1    header valid, one header per packet
//  i_hdr_tready    out  1    header consumed
//  i_tdata         in   64   payload data
//  i_tlast         in   1    last payload beat
//  i_tvalid        in   1    payload valid
//  i_tready        out  1    payload ready
//  o_tdata         out  64   CHDR stream data
//  o_tlast         out  1    end of CHDR packet
//  o_tvalid        out  1    CHDR valid
//  o_tready        in   1    downstream ready
//  o_len_err       out  1    1-cycle pulse: length field disagrees with the payload
// BEHAVIOUR
//  - Reset (async assert):
//      - state=ST_HDR; captured time=0; beat count=0; expected count=0; o_len_err=0.
//      - While reset is high, i_hdr_tready, i_tready and o_tvalid are forced 0.
//  - Latency: zero-cycle combinational pass-through; no data is registered except the
//    captured time word and the counters.
//  - ST_HDR:
//      - o_tdata=i_hdr[127:64]; o_tvalid=i_hdr_tvalid; i_hdr_tready=o_tready; i_tready=0.
//      - On o_tvalid&&o_tready, capture i_hdr[63:0], has_time, and the expected payload beats.
//      - exp = ceil((length - H)/8), where H=16 if has_time, else H=8.
//      - Use 17-bit arithmetic; exp is 14 bits.
//      - Next state: ST_TIME if has_time; else ST_BODY if exp>0; else ST_HDR.
//  - ST_TIME:
//      - o_tdata=captured time; o_tvalid=1; i_tready=0.
//      - On handshake: ST_BODY if exp>0, else ST_HDR.
//  - ST_BODY:
//      - o_tdata=i_tdata; o_tvalid=i_tvalid; i_tready=o_tready; o_tlast=i_tlast.
//      - Count beats on handshake.
//      - On the last handshake: go to ST_HDR and clear the count.
//  - o_tlast:
//      - 1 on the final word of every packet.
//      - Zero-payload packet (exp==0): the header word (no time) or the time word carries
//        o_tlast=1, and the payload stream is not touched.
//      - In ST_BODY, o_tlast follows i_tlast only; the length field never truncates or pads.
//  - o_len_err (LEN_CHECK=1), registered, pulses the cycle after:
//      - the last-beat handshake, if beats!=exp;
//      - the header handshake, if length<H (exp is forced to 0).
//  - Backpressure: o_tready=0 holds state, o_tdata and o_tvalid stable (AXI rules).
//  - A new header may be presented at any time; it is accepted only in ST_HDR.
//  - Reset mid-packet: the partial packet is abandoned and the next output starts with a header.
//  - Beat counter saturates at 16383; it does not wrap.
// STRUCTURE
//  - Shared package (cvita_pkg): header bit positions (HAS_TIME_BIT=125, EOB_BIT=124,
//    LEN_MSB/LSB=111/96), packet-type codes, H_NOTIME=8, H_TIME=16, state encodings.
//  - One natural sub-module: cvita_payload_beats (combinational; length,has_time -> exp, len_err).
//  - FSM, counter and mux live in this top module.
// TESTING
//  1. has_time=0, len=32, 3 payload beats, tlast on the 3rd, o_tready=1:
//     4 output beats, tlast on the 4th, o_len_err=0.
//  2. has_time=1, len=24, time=0x1122334455667788, 1 beat:
//     beats = hdr, 0x1122334455667788, payload; tlast on the 3rd.
//  3. has_time=0, len=8 (zero payload): a single output beat with tlast=1;
//     i_tready stays 0 throughout.
//  4. len=40 (exp=4), payload tlast after 2 beats:
//     3 output beats, tlast on the 3rd, o_len_err pulses 1 cycle.
//  5. o_tready toggling 1010..., i_tvalid random over 10 packets:
//     no data loss or duplication; o_tdata stable while stalled.
//  6. Assert reset during ST_BODY beat 2:
//     o_tvalid=0 immediately; after release, the next beat is the next header.

Source files
------------

// File: rtl/cvita_pkg.sv
// Shared CVITA/CHDR definitions: header field positions, packet types, header sizes
// and the framer state encoding.
package cvita_pkg;

   localparam int HAS_TIME_BIT = 125;
   localparam int EOB_BIT      = 124;
   localparam int LEN_MSB      = 111;
   localparam int LEN_LSB      = 96;
   localparam int PKT_TYPE_MSB = 127;
   localparam int PKT_TYPE_LSB = 126;

   localparam logic [1:0] PKT_TYPE_DATA = 2'b00;
   localparam logic [1:0] PKT_TYPE_FC   = 2'b01;
   localparam logic [1:0] PKT_TYPE_CMD  = 2'b10;
   localparam logic [1:0] PKT_TYPE_RESP = 2'b11;

   // Header bytes counted by the length field, in the 17-bit width used for length maths.
   localparam logic [16:0] H_NOTIME = 17'd8;
   localparam logic [16:0] H_TIME   = 17'd16;

   typedef enum logic [1:0] {
      ST_HDR  = 2'd0,
      ST_TIME = 2'd1,
      ST_BODY = 2'd2
   } state_t;

endpackage

// File: rtl/cvita_payload_beats.sv
// Converts a CVITA length field into the number of 64-bit payload beats it implies,
// flagging lengths too short to cover the header itself.
module cvita_payload_beats
   import cvita_pkg::*;
(
   input  logic [15:0] length,
   input  logic        has_time,
   output logic [13:0] exp_beats,
   output logic        len_short
);

   logic [16:0] hdr_bytes;
   logic [16:0] body_bytes;

   always_comb begin
      hdr_bytes  = has_time ? H_TIME : H_NOTIME;
      len_short  = ({1'b0, length} < hdr_bytes);
      body_bytes = {1'b0, length} - hdr_bytes;
      // Round partial trailing beats up; a short length means no payload at all.
      exp_beats  = len_short ? 14'd0 : 14'((body_bytes + 17'd7) >> 3);
   end

endmodule

// File: rtl/cvita_hdr_framer.sv
// Serialises a CVITA header (optionally followed by its VITA time word) and an
// AXI-Stream payload into a single 64-bit CHDR stream, checking the length field.
module cvita_hdr_framer
   import cvita_pkg::*;
#(
   parameter bit LEN_CHECK = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [127:0]  i_hdr,
   input  logic          i_hdr_tvalid,
   output logic          i_hdr_tready,
   input  logic [63:0]   i_tdata,
   input  logic          i_tlast,
   input  logic          i_tvalid,
   output logic          i_tready,
   output logic [63:0]   o_tdata,
   output logic          o_tlast,
   output logic          o_tvalid,
   input  logic          o_tready,
   output logic          o_len_err,
   output state_t        dbg_state
);

   // Handshakes: a word moves when valid && ready on a rising edge; a source holds
   // valid and data until that happens, and ready may depend combinationally on valid.
   state_t      state_q, state_d;
   logic [63:0] time_q;
   logic [13:0] exp_q;
   logic [13:0] hdr_exp;
   logic        hdr_short;
   logic        hdr_has_time;
   logic        out_hs, hdr_hs, body_hs, last_hs;

   assign hdr_has_time = i_hdr[HAS_TIME_BIT];
   assign dbg_state    = state_q;

   cvita_payload_beats u_beats (
      .length    (i_hdr[LEN_MSB:LEN_LSB]),
      .has_time  (hdr_has_time),
      .exp_beats (hdr_exp),
      .len_short (hdr_short)
   );

   assign out_hs  = o_tvalid && o_tready;
   assign hdr_hs  = out_hs && (state_q == ST_HDR);
   assign body_hs = out_hs && (state_q == ST_BODY);
   assign last_hs = body_hs && i_tlast;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_HDR;
         time_q  <= '0;
         exp_q   <= '0;
      end else begin
         state_q <= state_d;
         if (hdr_hs) begin
            time_q <= i_hdr[63:0];
            exp_q  <= hdr_exp;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_HDR: begin
            if (out_hs) begin
               if (hdr_has_time)        state_d = ST_TIME;
               else if (hdr_exp != '0)  state_d = ST_BODY;
               else                     state_d = ST_HDR;
            end
         end
         ST_TIME: begin
            if (out_hs) state_d = (exp_q != '0) ? ST_BODY : ST_HDR;
         end
         ST_BODY: begin
            if (last_hs) state_d = ST_HDR;
         end
         default: state_d = ST_HDR;
      endcase
   end

   always_comb begin
      o_tdata      = '0;
      o_tvalid     = 1'b0;
      o_tlast      = 1'b0;
      i_hdr_tready = 1'b0;
      i_tready     = 1'b0;
      case (state_q)
         ST_HDR: begin
            o_tdata      = i_hdr[127:64];
            o_tvalid     = i_hdr_tvalid;
            i_hdr_tready = o_tready;
            o_tlast      = !hdr_has_time && (hdr_exp == '0);
         end
         ST_TIME: begin
            o_tdata  = time_q;
            o_tvalid = 1'b1;
            o_tlast  = (exp_q == '0);
         end
         ST_BODY: begin
            o_tdata  = i_tdata;
            o_tvalid = i_tvalid;
            i_tready = o_tready;
            o_tlast  = i_tlast;
         end
         default: ;
      endcase
      if (reset) begin
         o_tvalid     = 1'b0;
         i_hdr_tready = 1'b0;
         i_tready     = 1'b0;
      end
   end

   if (LEN_CHECK) begin : g_len_check
      logic [13:0] beat_q;
      logic [13:0] beat_inc;
      logic        len_err_q;

      assign beat_inc  = (beat_q == 14'h3FFF) ? beat_q : beat_q + 14'd1;
      assign o_len_err = len_err_q;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            beat_q    <= '0;
            len_err_q <= 1'b0;
         end else begin
            if (last_hs)      beat_q <= '0;
            else if (body_hs) beat_q <= beat_inc;
            len_err_q <= (hdr_hs && hdr_short) || (last_hs && (beat_inc != exp_q));
         end
      end
   end else begin : g_no_len_check
      assign o_len_err = 1'b0;
   end

endmodule

// File: tb/tb_cvita_hdr_framer.sv
// Directed bench for cvita_hdr_framer: a table of packets with hand-computed outcomes,
// a randomised backpressure run and a mid-packet reset sequence.
module tb_cvita_hdr_framer;
   import cvita_pkg::*;

   localparam int W = 65;

   logic          clk = 1'b0;
   logic          reset;
   logic [127:0]  i_hdr;
   logic          i_hdr_tvalid;
   logic          i_hdr_tready;
   logic [63:0]   i_tdata;
   logic          i_tlast;
   logic          i_tvalid;
   logic          i_tready;
   logic [63:0]   o_tdata;
   logic          o_tlast;
   logic          o_tvalid;
   logic          o_tready;
   logic          o_len_err;
   state_t        dbg_state;

   int checks = 0;
   int errors = 0;
   int pkt_num = 0;
   logic [W-1:0] exp_q[$];

   typedef struct {
      logic        ht;
      logic [15:0] len;
      logic [63:0] tm;
      int          nbeats;
      logic        exp_err;
      int          exp_words;
   } vec_t;

   vec_t vecs[10];

   cvita_hdr_framer #(.LEN_CHECK(1'b1)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_hdr        (i_hdr),
      .i_hdr_tvalid (i_hdr_tvalid),
      .i_hdr_tready (i_hdr_tready),
      .i_tdata      (i_tdata),
      .i_tlast      (i_tlast),
      .i_tvalid     (i_tvalid),
      .i_tready     (i_tready),
      .o_tdata      (o_tdata),
      .o_tlast      (o_tlast),
      .o_tvalid     (o_tvalid),
      .o_tready     (o_tready),
      .o_len_err    (o_len_err),
      .dbg_state    (dbg_state)
   );

   // Clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic idle_inputs();
      i_hdr        = '0;
      i_hdr_tvalid = 1'b0;
      i_tdata      = '0;
      i_tlast      = 1'b0;
      i_tvalid     = 1'b0;
      o_tready     = 1'b1;
   endtask

   function automatic logic [63:0] make_hdr(input logic ht, input logic [15:0] len, input int num);
      logic [31:0] n;
      n = num;
      return {PKT_TYPE_DATA, ht, 1'b0, n[11:0], len, 16'hA5A5, n[15:0]};
   endfunction

   function automatic logic [63:0] make_pay(input int num, input int beat);
      logic [31:0] n;
      logic [31:0] b;
      n = num;
      b = beat;
      return {8'hD0, n[23:0], b};
   endfunction

   // Driver + monitor for one packet; expected words come from the bench model.
   task automatic run_packet(input logic ht, input logic [15:0] len, input logic [63:0] tm,
                             input int n, input bit toggle_rdy, input bit rand_vld,
                             input logic exp_err, input int exp_words);
      logic [63:0] hw;
      logic [63:0] pay[$];
      logic [63:0] last_data;
      int total, k, idx, words, err_cnt, tready_cnt, post;
      bit hdr_done, pv, stalled;

      hw    = make_hdr(ht, len, pkt_num);
      total = 1 + (ht ? 1 : 0) + n;
      k     = 0;
      exp_q.push_back({(k == total - 1), hw}); k++;
      if (ht) begin
         exp_q.push_back({(k == total - 1), tm}); k++;
      end
      for (int i = 0; i < n; i++) begin
         pay.push_back(make_pay(pkt_num, i));
         exp_q.push_back({(k == total - 1), make_pay(pkt_num, i)}); k++;
      end

      i_hdr = {hw, tm};
      hdr_done = 0; pv = 0; stalled = 0; last_data = '0;
      idx = 0; words = 0; err_cnt = 0; tready_cnt = 0; post = 0;

      for (int cyc = 0; cyc < 300 && post < 3; cyc++) begin
         @(negedge clk);
         o_tready     = toggle_rdy ? (cyc % 2 == 0) : 1'b1;
         i_hdr_tvalid = !hdr_done;
         if (idx < n) begin
            if (!pv) pv = rand_vld ? ($urandom_range(0, 1) == 1) : 1'b1;
         end else begin
            pv = 0;
         end
         i_tvalid = pv;
         i_tdata  = (idx < n) ? pay[idx] : 64'd0;
         i_tlast  = (idx == n - 1);
         #1;
         if (stalled) check("stall_hold", {o_tvalid, o_tdata}, {1'b1, last_data});
         stalled   = o_tvalid && !o_tready;
         last_data = o_tdata;
         if (o_len_err) err_cnt++;
         if (n == 0 && i_tready) tready_cnt++;
         if (o_tvalid && o_tready) begin
            words++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_word: got %h expected no word", {o_tlast, o_tdata});
            end else begin
               check("out_word", {o_tlast, o_tdata}, exp_q.pop_front());
            end
         end
         if (i_hdr_tvalid && i_hdr_tready) hdr_done = 1;
         if (i_tvalid && i_tready) begin
            idx++;
            pv = 0;
         end
         if (hdr_done && exp_q.size() == 0 && idx >= n) post++;
      end

      if (post < 3) begin
         checks++;
         errors++;
         $display("FAIL timeout: packet %0d got %0d words expected %0d", pkt_num, words, exp_words);
         exp_q.delete();
      end
      check("word_count", words, exp_words);
      check("len_err_pulses", err_cnt, exp_err);
      if (n == 0) check("tready_idle", tready_cnt, 0);
      i_hdr_tvalid = 1'b0;
      i_tvalid     = 1'b0;
      pkt_num++;
   endtask

   initial begin
      logic [63:0] hw;
      bit ht;
      int n;
      logic [15:0] len;

      //            ht    len    time                    n  err  words
      vecs[0] = '{1'b0, 16'd32, 64'h0,                  3, 1'b0, 4};
      vecs[1] = '{1'b1, 16'd24, 64'h1122334455667788,   1, 1'b0, 3};
      vecs[2] = '{1'b0, 16'd8,  64'h0,                  0, 1'b0, 1};
      vecs[3] = '{1'b0, 16'd40, 64'h0,                  2, 1'b1, 3};
      vecs[4] = '{1'b0, 16'd4,  64'h0,                  0, 1'b1, 1};
      vecs[5] = '{1'b1, 16'd16, 64'hCAFEF00D12345678,   0, 1'b0, 2};
      vecs[6] = '{1'b1, 16'd8,  64'h0BADBEEF0BADBEEF,   0, 1'b1, 2};
      vecs[7] = '{1'b0, 16'd33, 64'h0,                  4, 1'b0, 5};
      vecs[8] = '{1'b1, 16'd17, 64'h8877665544332211,   1, 1'b0, 3};
      vecs[9] = '{1'b0, 16'd16, 64'h0,                  3, 1'b1, 4};

      // Reset with inputs active: handshakes must stay blocked.
      idle_inputs();
      reset        = 1'b1;
      i_hdr_tvalid = 1'b1;
      i_tvalid     = 1'b1;
      #12;
      check("rst_o_tvalid", o_tvalid, 1'b0);
      check("rst_i_hdr_tready", i_hdr_tready, 1'b0);
      check("rst_i_tready", i_tready, 1'b0);
      check("rst_len_err", o_len_err, 1'b0);
      check("rst_state", dbg_state, ST_HDR);
      @(negedge clk);
      idle_inputs();
      reset = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 10; v++)
         run_packet(vecs[v].ht, vecs[v].len, vecs[v].tm, vecs[v].nbeats, 1'b0, 1'b0,
                    vecs[v].exp_err, vecs[v].exp_words);

      // Backpressure 1010... with random payload valid, exact lengths.
      for (int p = 0; p < 10; p++) begin
         ht  = ($urandom_range(0, 1) == 1);
         n   = $urandom_range(1, 5);
         len = 16'((ht ? 16 : 8) + 8 * (n - 1) + $urandom_range(1, 8));
         run_packet(ht, len, {32'h7100_0000, 32'(p)}, n, 1'b1, 1'b1, 1'b0, 1 + (ht ? 1 : 0) + n);
      end

      // Reset asserted while the second payload beat is on the output.
      hw = make_hdr(1'b0, 16'd40, pkt_num);
      @(negedge clk);
      o_tready     = 1'b1;
      i_hdr        = {hw, 64'h0};
      i_hdr_tvalid = 1'b1;
      i_tvalid     = 1'b1;
      i_tdata      = make_pay(pkt_num, 0);
      i_tlast      = 1'b0;
      #1;
      check("mid_rst_hdr", {o_tvalid, o_tdata}, {1'b1, hw});
      @(negedge clk);
      i_hdr_tvalid = 1'b0;
      #1;
      check("mid_rst_beat1", {o_tvalid, o_tdata}, {1'b1, make_pay(pkt_num, 0)});
      @(negedge clk);
      i_tdata = make_pay(pkt_num, 1);
      #1;
      check("mid_rst_body_state", dbg_state, ST_BODY);
      reset = 1'b1;
      #1;
      check("mid_rst_o_tvalid", o_tvalid, 1'b0);
      check("mid_rst_i_tready", i_tready, 1'b0);
      check("mid_rst_state", dbg_state, ST_HDR);
      @(negedge clk);
      check("mid_rst_len_err", o_len_err, 1'b0);
      idle_inputs();
      reset = 1'b0;
      pkt_num++;
      run_packet(1'b0, 16'd24, 64'h0, 2, 1'b0, 1'b0, 1'b0, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
